cla_nibble_seq: RTL and testbench
=================================

# cla_nibble_seq

Multi-cycle adder controller that sequences one shared 4-bit carry-lookahead adder slice (pgu + carry_gen + sum XOR) to add WIDTH-bit operands, one nibble per clock, least-significant nibble first. It latches an operand pair on a valid/ready handshake, iterates the slice with the carry held in a register, and presents sum, carry-out and signed overflow on a second valid/ready handshake. It sits between the operand source and the adder slice; the slice itself stays combinational and external.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4; NIB = WIDTH/4
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start_valid  input  1  operand pair and cin are valid
- start_ready  output  1  controller can accept operands
- a, b  input  WIDTH  operands, sampled on accept
- cin  input  1  carry into bit 0, sampled on accept
- result_valid  output  1  sum/cout/overflow are valid
- result_ready  input  1  consumer takes the result
- sum  output  WIDTH  registered result
- cout  output  1  carry out of bit WIDTH-1
- overflow  output  1  two's-complement overflow
- busy  output  1  high in RUN
- slice_a, slice_b  output  4  nibble fed to the adder slice
- slice_cin  output  1  carry fed to the slice
- slice_sum  input  4  slice sum, combinational from slice inputs
- slice_cout  input  1  slice carry-out

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start_ready=1. When start_valid is high at a clock edge: latch a, b, cin into a_reg, b_reg, carry_reg; clear idx and sum_reg; go to RUN.
- RUN: slice_a=a_reg[4*idx+3:4*idx], slice_b=b_reg[same bits], slice_cin=carry_reg. At each edge: sum_reg nibble idx <= slice_sum, carry_reg <= slice_cout, idx <= idx+1. When idx==NIB-1 at that edge, go to DONE.
- DONE: result_valid=1, sum=sum_reg, cout=carry_reg, overflow=(a_reg[W-1]==b_reg[W-1]) && (sum_reg[W-1]!=a_reg[W-1]). When result_ready is high at an edge, go to IDLE.
- Outside RUN, slice_a, slice_b and slice_cin are driven 0.
- start_ready=0 in RUN and DONE. start_valid is ignored there; there is no accept in the same cycle as the DONE->IDLE exit.
- The sum, cout and overflow outputs hold their last values in IDLE. They are valid only while result_valid is high.
- idx width is clog2(NIB), minimum 1 bit. idx does not wrap in normal operation; it is cleared on accept.
- Arithmetic is unsigned modulo 2^WIDTH. cout is the true bit-WIDTH carry. overflow is the signed-interpretation flag.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, idx=0; a_reg, b_reg, sum_reg, carry_reg=0; start_ready=1; result_valid=0; busy=0; sum=0, cout=0, overflow=0; slice outputs 0.
- Reset asserted mid-RUN or mid-DONE: the operation is abandoned at once and no result is produced. After release, the controller is in IDLE.
- Latency: accept at edge E0. RUN occupies cycles E0..E0+NIB. result_valid rises after edge E0+NIB, so it is observable NIB cycles after accept.
- With WIDTH=4: one RUN cycle, then DONE.
- Throughput: at most one operation per NIB+2 cycles when result_ready is held high.
- Control outputs (start_ready, result_valid, busy) decode directly from state. Slice outputs are combinational from the registers and idx.
- Backpressure: DONE holds indefinitely with result_valid=1 and outputs stable until result_ready is high.

## Test plan
- WIDTH=16, a=0x0001, b=0xFFFF, cin=0 → result_valid 4 cycles after accept; sum=0x0000, cout=1, overflow=0. Carry must ripple through all four nibble boundaries.
- a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, cout=0, overflow=1. Also a=0x8000, b=0x8000 → sum=0x0000, cout=1, overflow=1.
- a=0x0FFF, b=0x0000, cin=1 → sum=0x1000, cout=0, overflow=0. Check slice_cin=1 in the first RUN cycle and slice_a sequence F, F, F, 0.
- Hold result_ready low for 5 cycles in DONE while pulsing start_valid → result_valid stays 1, sum unchanged, start_ready=0, and no new operands are latched. Raise result_ready → IDLE next cycle.
- Assert rst_n low during the 2nd RUN cycle → all outputs go to reset values immediately. After release, a new operation (0x1234 + 0x1111) gives sum=0x2345.
- WIDTH=4 instance: a=0xF, b=0x1, cin=0 → sum=0x0, cout=1, overflow=0 after 1 RUN cycle. Then 256 random 16-bit pairs compared against a+b+cin.

Source files
------------

// File: rtl/cla_nibble_seq.sv
// Multi-cycle adder controller. One external 4-bit carry-lookahead slice is reused
// once per nibble, least-significant first, with the inter-nibble carry kept in a register.
module cla_nibble_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             busy,
    output logic [3:0]       slice_a,
    output logic [3:0]       slice_b,
    output logic             slice_cin,
    input  logic [3:0]       slice_sum,
    input  logic             slice_cout
);

    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                state;
    logic [IW-1:0]         idx;
    logic [NIB-1:0][3:0]   a_reg;
    logic [NIB-1:0][3:0]   b_reg;
    logic [NIB-1:0][3:0]   sum_reg;
    logic                  carry_reg;

    // idx parks on the last nibble instead of incrementing past it, so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= cin;
                        idx       <= '0;
                        sum_reg   <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    sum_reg[idx] <= slice_sum;
                    carry_reg    <= slice_cout;
                    if (idx == LAST) begin
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        slice_a   = 4'h0;
        slice_b   = 4'h0;
        slice_cin = 1'b0;
        if (state == RUN) begin
            slice_a   = a_reg[idx];
            slice_b   = b_reg[idx];
            slice_cin = carry_reg;
        end
    end

    assign start_ready  = (state == IDLE);
    assign busy         = (state == RUN);
    assign result_valid = (state == DONE);
    assign sum          = sum_reg;
    assign cout         = carry_reg;
    // Same-sign operands producing an opposite-sign result.
    assign overflow     = (a_reg[NIB-1][3] == b_reg[NIB-1][3]) &&
                          (sum_reg[NIB-1][3] != a_reg[NIB-1][3]);

endmodule

// File: tb/tb_cla_nibble_seq.sv
// Self-checking bench for cla_nibble_seq: a 16-bit and a 4-bit instance, each driving
// a behavioural adder slice, checked against whole-word arithmetic.
module tb_cla_nibble_seq;

    logic        clk = 1'b0;
    logic        rstN;

    logic        startValid, startReady, resultValid, resultReady;
    logic [15:0] opA, opB, sumOut;
    logic        opCin, coutOut, ovfOut, busyOut;
    logic [3:0]  sliceA, sliceB, sliceSum;
    logic        sliceCin, sliceCout;

    logic        startValid4, startReady4, resultValid4, resultReady4;
    logic [3:0]  opA4, opB4, sumOut4;
    logic        opCin4, coutOut4, ovfOut4, busyOut4;
    logic [3:0]  sliceA4, sliceB4, sliceSum4;
    logic        sliceCin4, sliceCout4;

    int          checks = 0;
    int          errors = 0;
    logic [3:0]  sliceHist [0:7];
    logic        firstCin;

    always #5 clk = ~clk;

    // External adder slices modelled as plain 4-bit addition.
    assign {sliceCout, sliceSum}   = {1'b0, sliceA} + {1'b0, sliceB} + {4'b0, sliceCin};
    assign {sliceCout4, sliceSum4} = {1'b0, sliceA4} + {1'b0, sliceB4} + {4'b0, sliceCin4};

    cla_nibble_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rstN),
        .start_valid(startValid), .start_ready(startReady),
        .a(opA), .b(opB), .cin(opCin),
        .result_valid(resultValid), .result_ready(resultReady),
        .sum(sumOut), .cout(coutOut), .overflow(ovfOut), .busy(busyOut),
        .slice_a(sliceA), .slice_b(sliceB), .slice_cin(sliceCin),
        .slice_sum(sliceSum), .slice_cout(sliceCout)
    );

    cla_nibble_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rstN),
        .start_valid(startValid4), .start_ready(startReady4),
        .a(opA4), .b(opB4), .cin(opCin4),
        .result_valid(resultValid4), .result_ready(resultReady4),
        .sum(sumOut4), .cout(coutOut4), .overflow(ovfOut4), .busy(busyOut4),
        .slice_a(sliceA4), .slice_b(sliceB4), .slice_cin(sliceCin4),
        .slice_sum(sliceSum4), .slice_cout(sliceCout4)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Offers one operand pair, then waits (bounded) for result_valid, logging slice_a per RUN cycle.
    task automatic applyStimulus(input logic [15:0] ta, input logic [15:0] tb,
                                 input logic tc, output int lat);
        int n;
        n = 0;
        while (!startReady && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        startValid = 1'b1;
        opA = ta;
        opB = tb;
        opCin = tc;
        @(posedge clk); #1;
        startValid = 1'b0;
        opA = 16'h0;
        opB = 16'h0;
        opCin = 1'b0;
        lat = 0;
        firstCin = sliceCin;
        while (!resultValid && lat < 40) begin
            if (lat < 8) sliceHist[lat] = sliceA;
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 40) checkOutput("result_timeout", 32'(resultValid), 32'd1);
    endtask

    task automatic expectResult(input string tag, input logic [15:0] ta,
                                input logic [15:0] tb, input logic tc);
        logic [16:0] full;
        logic        ovf;
        full = {1'b0, ta} + {1'b0, tb} + {16'b0, tc};
        ovf  = (ta[15] == tb[15]) && (full[15] != ta[15]);
        checkOutput({tag, "_sum"}, 32'(sumOut), 32'(full[15:0]));
        checkOutput({tag, "_cout"}, 32'(coutOut), 32'(full[16]));
        checkOutput({tag, "_ovf"}, 32'(ovfOut), 32'(ovf));
    endtask

    task automatic releaseResult();
        resultReady = 1'b1;
        @(posedge clk); #1;
        resultReady = 1'b0;
    endtask

    initial begin
        int lat;
        int n;
        logic [15:0] ra, rb, held;
        logic        rc;

        rstN = 1'b0;
        startValid = 1'b0; resultReady = 1'b0; opA = '0; opB = '0; opCin = 1'b0;
        startValid4 = 1'b0; resultReady4 = 1'b0; opA4 = '0; opB4 = '0; opCin4 = 1'b0;
        #23;
        checkOutput("rst_start_ready", 32'(startReady), 32'd1);
        checkOutput("rst_result_valid", 32'(resultValid), 32'd0);
        checkOutput("rst_busy", 32'(busyOut), 32'd0);
        checkOutput("rst_sum", 32'(sumOut), 32'd0);
        checkOutput("rst_cout", 32'(coutOut), 32'd0);
        checkOutput("rst_ovf", 32'(ovfOut), 32'd0);
        checkOutput("rst_slice", 32'({sliceA, sliceB, sliceCin}), 32'd0);
        rstN = 1'b1;
        @(posedge clk); #1;

        // Carry ripples across every nibble boundary.
        applyStimulus(16'h0001, 16'hFFFF, 1'b0, lat);
        checkOutput("ripple_latency", 32'(lat), 32'd4);
        checkOutput("ripple_sum", 32'(sumOut), 32'h0000);
        checkOutput("ripple_cout", 32'(coutOut), 32'd1);
        checkOutput("ripple_ovf", 32'(ovfOut), 32'd0);
        releaseResult();

        applyStimulus(16'h7FFF, 16'h0001, 1'b0, lat);
        checkOutput("posovf_sum", 32'(sumOut), 32'h8000);
        checkOutput("posovf_cout", 32'(coutOut), 32'd0);
        checkOutput("posovf_ovf", 32'(ovfOut), 32'd1);
        releaseResult();

        applyStimulus(16'h8000, 16'h8000, 1'b0, lat);
        checkOutput("negovf_sum", 32'(sumOut), 32'h0000);
        checkOutput("negovf_cout", 32'(coutOut), 32'd1);
        checkOutput("negovf_ovf", 32'(ovfOut), 32'd1);
        releaseResult();

        applyStimulus(16'h0FFF, 16'h0000, 1'b1, lat);
        checkOutput("cin_first_slice_cin", 32'(firstCin), 32'd1);
        checkOutput("cin_slice_seq", 32'({sliceHist[0], sliceHist[1], sliceHist[2], sliceHist[3]}),
                    32'h0000FFF0);
        checkOutput("cin_sum", 32'(sumOut), 32'h1000);
        checkOutput("cin_cout", 32'(coutOut), 32'd0);
        checkOutput("cin_ovf", 32'(ovfOut), 32'd0);
        releaseResult();

        // Backpressure: DONE must hold while start_valid is waved at it.
        applyStimulus(16'h1234, 16'h4321, 1'b0, lat);
        held = sumOut;
        checkOutput("bp_sum_initial", 32'(held), 32'h5555);
        for (int i = 0; i < 5; i++) begin
            startValid = 1'b1;
            opA = 16'(i * 16'h1111 + 16'h0F0F);
            opB = 16'hAAAA;
            @(posedge clk); #1;
            checkOutput("bp_result_valid", 32'(resultValid), 32'd1);
            checkOutput("bp_start_ready", 32'(startReady), 32'd0);
            checkOutput("bp_sum_hold", 32'(sumOut), 32'(held));
        end
        resultReady = 1'b1;
        @(posedge clk); #1;
        resultReady = 1'b0;
        checkOutput("bp_exit_idle", 32'(startReady), 32'd1);
        checkOutput("bp_exit_no_accept", 32'(busyOut), 32'd0);
        checkOutput("bp_idle_sum_hold", 32'(sumOut), 32'(held));
        startValid = 1'b0;
        opA = '0;
        opB = '0;

        // Reset in the second RUN cycle abandons the operation.
        startValid = 1'b1;
        opA = 16'hABCD;
        opB = 16'h1111;
        @(posedge clk); #1;
        startValid = 1'b0;
        @(posedge clk); #1;
        checkOutput("midrst_busy_before", 32'(busyOut), 32'd1);
        rstN = 1'b0;
        #1;
        checkOutput("midrst_busy", 32'(busyOut), 32'd0);
        checkOutput("midrst_start_ready", 32'(startReady), 32'd1);
        checkOutput("midrst_result_valid", 32'(resultValid), 32'd0);
        checkOutput("midrst_sum", 32'(sumOut), 32'd0);
        checkOutput("midrst_cout", 32'(coutOut), 32'd0);
        checkOutput("midrst_slice", 32'({sliceA, sliceB, sliceCin}), 32'd0);
        #10;
        rstN = 1'b1;
        @(posedge clk); #1;
        applyStimulus(16'h1234, 16'h1111, 1'b0, lat);
        checkOutput("postrst_sum", 32'(sumOut), 32'h2345);
        releaseResult();

        // Single-nibble instance: one RUN cycle only.
        startValid4 = 1'b1;
        opA4 = 4'hF;
        opB4 = 4'h1;
        opCin4 = 1'b0;
        @(posedge clk); #1;
        startValid4 = 1'b0;
        n = 0;
        while (!resultValid4 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("w4_latency", 32'(n), 32'd1);
        checkOutput("w4_sum", 32'(sumOut4), 32'h0);
        checkOutput("w4_cout", 32'(coutOut4), 32'd1);
        checkOutput("w4_ovf", 32'(ovfOut4), 32'd0);
        resultReady4 = 1'b1;
        @(posedge clk); #1;
        resultReady4 = 1'b0;
        checkOutput("w4_exit_idle", 32'(startReady4), 32'd1);

        for (int i = 0; i < 256; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            applyStimulus(ra, rb, rc, lat);
            checkOutput("rand_latency", 32'(lat), 32'd4);
            expectResult("rand", ra, rb, rc);
            n = $urandom_range(0, 2);
            for (int w = 0; w < n; w++) begin
                @(posedge clk); #1;
            end
            releaseResult();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
